// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// imem_loader_if : load-stream handshake and fetch port of the instruction RAM
// Revision 1.0
// ============================================================================
interface imem_loader_if #(
    parameter int N = 32
);
    logic           load_start;
    logic [6:0]     load_len;
    logic           rx_valid;
    logic [7:0]     rx_data;
    logic           rx_ready;
    logic [5:0]     addr;
    logic [N-1:0]   q;
    logic           busy;
    logic           done;
    logic [6:0]     wr_count;

    modport master (
        output load_start, load_len, rx_valid, rx_data, addr,
        input  rx_ready, q, busy, done, wr_count
    );

    modport slave (
        input  load_start, load_len, rx_valid, rx_data, addr,
        output rx_ready, q, busy, done, wr_count
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// imem_loader : run-time writable instruction RAM filled from a LE byte stream
// Revision 1.0
// ============================================================================
module imem_loader #(
    parameter int N     = 32,
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);
    localparam int             BPW         = N / 8;
    localparam int             BIW         = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BIW-1:0] C_LAST_BYTE = BIW'(BPW - 1);
    localparam logic [6:0]     C_DEPTH     = 7'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [6:0]      len_q, len_d;
    logic [6:0]      word_idx_q, word_idx_d;
    logic [6:0]      wr_count_q, wr_count_d;
    logic [BIW-1:0]  byte_idx_q, byte_idx_d;
    logic [N-1:0]    asm_q, asm_d;
    logic            rx_ready_q, busy_q, done_q;
    logic [N-1:0]    mem_q [DEPTH];

    logic            accept;
    logic            wr_en;
    logic [N-1:0]    wr_data;
    logic [6:0]      len_clamped;

    always_comb begin
        len_clamped = (bus.load_len > C_DEPTH) ? C_DEPTH : bus.load_len;
        accept      = rx_ready_q && bus.rx_valid;
        wr_en       = accept && (byte_idx_q == C_LAST_BYTE);
        // The final byte bypasses the assembly register so the word lands on its own edge.
        wr_data                   = asm_q;
        wr_data[8*(BPW-1) +: 8]   = bus.rx_data;

        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        wr_count_d = wr_count_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.load_start) begin
                    wr_count_d = '0;
                    if (len_clamped == 7'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_RECV;
                        len_d      = len_clamped;
                        word_idx_d = '0;
                        byte_idx_d = '0;
                        asm_d      = '0;
                    end
                end
            end
            ST_RECV: begin
                if (wr_en) begin
                    word_idx_d = word_idx_q + 7'd1;
                    wr_count_d = wr_count_q + 7'd1;
                    byte_idx_d = '0;
                    if (word_idx_q == len_q - 7'd1) begin
                        state_d = ST_DONE;
                    end
                end else if (accept) begin
                    byte_idx_d = byte_idx_q + BIW'(1);
                    for (int k = 0; k < BPW; k++) begin
                        if (byte_idx_q == BIW'(k)) begin
                            asm_d[8*k +: 8] = bus.rx_data;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            wr_count_q <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            wr_count_q <= wr_count_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            rx_ready_q <= (state_d == ST_RECV);
            busy_q     <= (state_d == ST_RECV);
            done_q     <= (state_d == ST_DONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[word_idx_q[5:0]] <= wr_data;
        end
    end

    assign bus.rx_ready = rx_ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.wr_count = wr_count_q;
    assign bus.q        = mem_q[bus.addr];
endmodule
`default_nettype wire
